// File: rtl/sum_arbiter_pkg.sv
// Shared constants and helpers for the sum adder arbiter.
// Default adder width and requester ceiling live here.
package sum_arbiter_pkg;

  localparam int SUM_WIDTH   = 16;
  localparam int ARB_MAX_REQ = 8;

  // Width of a counter/index holding values 0..n-1, never zero.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sum_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible
// requester at or after the pointer, wrapping.
module rr_pick
  import sum_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic [N-1:0]  excl_i,
  output logic [N-1:0]  pick_o,
  output logic [PW-1:0] nxt_ptr_o,
  output logic          any_o
);

  logic [N-1:0] elig;

  assign elig = req_i & ~excl_i;

  // Pass one scans [ptr, N), pass two wraps over [0, ptr).
  always_comb begin
    pick_o    = '0;
    nxt_ptr_o = ptr_i;
    any_o     = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!any_o && elig[j] && (j >= int'(ptr_i))) begin
        pick_o[j] = 1'b1;
        nxt_ptr_o = PW'((j + 1) % N);
        any_o     = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!any_o && elig[j]) begin
        pick_o[j] = 1'b1;
        nxt_ptr_o = PW'((j + 1) % N);
        any_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sum_arbiter.sv
// Round-robin owner of the single shared sum adder with
// registered one-hot grant and optional hold limit.
module sum_arbiter
  import sum_arbiter_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int WIDTH    = SUM_WIDTH,
  parameter int MAX_HOLD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_i,
  input  logic [N_REQ*WIDTH-1:0] b_i,
  output logic [N_REQ-1:0]       grant,
  output logic [WIDTH-1:0]       res,
  output logic                   busy,
  output logic [WIDTH-1:0]       sum_in_a,
  output logic [WIDTH-1:0]       sum_in_b,
  input  logic [WIDTH-1:0]       sum_out
);

  localparam int PW = ptr_w(N_REQ);
  localparam int HW = ptr_w(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  logic [N_REQ-1:0] grant_q, grant_d, pick;
  logic [PW-1:0]    ptr_q, ptr_d, pick_ptr;
  logic [HW-1:0]    hold_q, hold_d;
  logic             pick_any, keep, preempt;

  // Owner is excluded so a preempted or released owner is skipped.
  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .excl_i    (grant_q),
    .pick_o    (pick),
    .nxt_ptr_o (pick_ptr),
    .any_o     (pick_any)
  );

  assign preempt = (MAX_HOLD > 0)
                && (hold_q == HOLD_LAST)
                && |(req & ~grant_q);
  assign keep    = |(grant_q & req) && !preempt;

  // hold_q saturates at HOLD_LAST so a late waiter is still served.
  always_comb begin
    grant_d = pick;
    ptr_d   = ptr_q;
    hold_d  = '0;
    if (keep) begin
      grant_d = grant_q;
      hold_d  = (hold_q != HOLD_LAST) ? hold_q + 1'b1 : hold_q;
    end else if (pick_any) begin
      ptr_d = pick_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    sum_in_a = '0;
    sum_in_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sum_in_a = sum_in_a | a_i[i*WIDTH +: WIDTH];
        sum_in_b = sum_in_b | b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  assign grant = grant_q;
  assign busy  = |grant_q;
  assign res   = sum_out;

endmodule

// File: tb/tb_sum_arbiter.sv
// Bench for sum_arbiter: directed scenarios plus random
// traffic against a queue-free owner/pointer model.
module tb_sum_arbiter;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_i, b_i;
  logic [N-1:0]   grant;
  logic [W-1:0]   res, sum_in_a, sum_in_b, sum_out;
  logic           busy;

  int checks = 0;
  int passed = 0;

  int m_own  = -1;
  int m_ptr  = 0;
  int m_hold = 0;

  sum_arbiter #(
    .N_REQ    (N),
    .WIDTH    (W),
    .MAX_HOLD (MH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .a_i      (a_i),
    .b_i      (b_i),
    .grant    (grant),
    .res      (res),
    .busy     (busy),
    .sum_in_a (sum_in_a),
    .sum_in_b (sum_in_b),
    .sum_out  (sum_out)
  );

  assign sum_out = sum_in_a + sum_in_b;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    checks++;
    if ($countones(grant) > 1)
      $display("FAIL onehot: grant=%b has more than one bit", grant);
    else
      passed++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Ownership model: owner keeps while requesting unless it has
  // held MH cycles with someone waiting; else next at/after pointer.
  task automatic model_edge(input logic [N-1:0] r, input logic rs);
    int excl;
    int j;
    bit waiting;
    if (rs) begin
      m_own = -1; m_ptr = 0; m_hold = 0;
      return;
    end
    if (m_own >= 0 && r[m_own]) begin
      waiting = (r & ~(N'(1) << m_own)) != '0;
      if (!(waiting && m_hold >= MH - 1)) begin
        m_hold++;
        return;
      end
    end
    excl = m_own;
    m_own = -1;
    m_hold = 0;
    for (int k = 0; k < N; k++) begin
      j = (m_ptr + k) % N;
      if (r[j] && j != excl) begin
        m_own = j;
        m_ptr = (j + 1) % N;
        break;
      end
    end
  endtask

  function automatic logic [N-1:0] m_grant();
    return (m_own >= 0) ? (N'(1) << m_own) : '0;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic rs);
    req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    a_i[i*W +: W] = a;
    b_i[i*W +: W] = b;
  endtask

  task automatic test_reset();
    for (int i = 0; i < N; i++)
      set_op(i, W'($urandom) | 16'h1, W'($urandom) | 16'h1);
    for (int c = 0; c < 3; c++) begin
      drive(3'b011, 1'b1);
      checks++;
      if ({grant, busy, sum_in_a, sum_in_b} !== '0)
        $display("FAIL reset c%0d: grant=%b busy=%b a=%h b=%h want all 0",
                 c, grant, busy, sum_in_a, sum_in_b);
      else passed++;
    end
  endtask

  task automatic test_single();
    drive(3'b000, 1'b1);
    set_op(0, 16'd7, 16'd9);
    drive(3'b001, 1'b0);
    checks++;
    if (grant !== 3'b001)
      $display("FAIL single_grant: got %b want 001", grant);
    else passed++;
    checks++;
    if (res !== 16'd16)
      $display("FAIL single_res: got %0d want 16", res);
    else passed++;
    drive(3'b000, 1'b0);
    checks++;
    if ({grant, busy} !== 4'b0000)
      $display("FAIL single_release: grant=%b busy=%b want 000/0",
               grant, busy);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] rq [4];
    logic [N-1:0] ex [4];
    rq = '{3'b011, 3'b010, 3'b000, 3'b011};
    ex = '{3'b001, 3'b010, 3'b000, 3'b001};
    drive(3'b000, 1'b1);
    for (int s = 0; s < 4; s++) begin
      drive(rq[s], 1'b0);
      checks++;
      if (grant !== ex[s])
        $display("FAIL simul s%0d: got %b want %b", s, grant, ex[s]);
      else passed++;
    end
  endtask

  task automatic test_hold_limit();
    logic [N-1:0] ex;
    drive(3'b000, 1'b1);
    for (int k = 0; k < 16; k++) begin
      drive(3'b011, 1'b0);
      ex = ((k / MH) % 2 == 0) ? 3'b001 : 3'b010;
      checks++;
      if (grant !== ex)
        $display("FAIL hold k%0d: got %b want %b", k, grant, ex);
      else passed++;
    end
  endtask

  task automatic test_mid_reset();
    drive(3'b000, 1'b1);
    drive(3'b010, 1'b0);
    checks++;
    if (grant !== 3'b010)
      $display("FAIL midrst_own: got %b want 010", grant);
    else passed++;
    drive(3'b010, 1'b1);
    checks++;
    if (grant !== 3'b000)
      $display("FAIL midrst_drop: got %b want 000", grant);
    else passed++;
    drive(3'b011, 1'b0);
    checks++;
    if (grant !== 3'b001)
      $display("FAIL midrst_regrant: got %b want 001", grant);
    else passed++;
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic         rs;
    logic [W-1:0] ea, eb;
    r = '0;
    drive(3'b000, 1'b1);
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(3) == 0) r[i] = ~r[i];
        set_op(i, W'($urandom), W'($urandom));
      end
      rs = ($urandom_range(99) == 0);
      drive(r, rs);
      ea = (m_own >= 0) ? a_i[m_own*W +: W] : '0;
      eb = (m_own >= 0) ? b_i[m_own*W +: W] : '0;
      checks++;
      if (grant !== m_grant() || busy !== (m_own >= 0))
        $display("FAIL rand_grant c%0d: got %b/%b want %b", c,
                 grant, busy, m_grant());
      else passed++;
      checks++;
      if (sum_in_a !== ea || sum_in_b !== eb || res !== W'(ea + eb))
        $display("FAIL rand_data c%0d: a=%h b=%h res=%h want %h %h %h",
                 c, sum_in_a, sum_in_b, res, ea, eb, W'(ea + eb));
      else passed++;
    end
  endtask

  // Two accumulating requesters share the adder until both finish.
  task automatic test_back_to_back();
    logic [W-1:0] v0, v2, acc0, acc2, nx;
    int rem0, rem2, k0, k2, cyc;
    bit u0, u2;
    v0 = W'($urandom); v2 = W'($urandom);
    acc0 = '0; acc2 = '0;
    k0 = 10; k2 = 13;
    rem0 = k0; rem2 = k2;
    cyc = 0;
    drive(3'b000, 1'b1);
    while ((rem0 > 0 || rem2 > 0) && cyc < 400) begin
      set_op(0, acc0, v0);
      set_op(1, '0, '0);
      set_op(2, acc2, v2);
      #1;
      checks++;
      if (grant !== m_grant())
        $display("FAIL share_grant c%0d: got %b want %b", cyc,
                 grant, m_grant());
      else passed++;
      u0 = grant[0] && rem0 > 0;
      u2 = grant[2] && rem2 > 0;
      nx = res;
      drive({rem2 > 0, 1'b0, rem0 > 0}, 1'b0);
      if (u0) begin acc0 = nx; rem0--; end
      if (u2) begin acc2 = nx; rem2--; end
      cyc++;
    end
    checks++;
    if (rem0 != 0 || rem2 != 0)
      $display("FAIL share_timeout: rem0=%0d rem2=%0d want 0/0",
               rem0, rem2);
    else passed++;
    checks++;
    if (acc0 !== W'(k0 * v0))
      $display("FAIL share_acc0: got %h want %h", acc0, W'(k0 * v0));
    else passed++;
    checks++;
    if (acc2 !== W'(k2 * v2))
      $display("FAIL share_acc2: got %h want %h", acc2, W'(k2 * v2));
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    a_i = '0;
    b_i = '0;
    #1;
    test_reset();
    test_single();
    test_simultaneous();
    test_hold_limit();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
